elevator_call_scheduler: RTL and testbench

ELEVATOR_CALL_SCHEDULER -- requirements
Module: elevator_call_scheduler

---
 rtl/elevator_call_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_elevator_call_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_call_scheduler.sv
// Three-floor elevator call scheduler: button capture, sweep-ordered target selection, dispatch handshake.
// Define ELEVATOR_DOOR_DWELL_EN to hold doors open for DWELL_CYCLES; otherwise ARRIVED lasts one cycle.
module elevator_call_scheduler #(
    parameter int unsigned DWELL_CYCLES     = 1000,
    parameter int unsigned DISPATCH_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] btn,
    input  logic [2:0] f,
    input  logic       mup,
    input  logic       mdw,
    output logic [2:0] p,
    output logic       s,
    output logic [2:0] pend,
    output logic       door_open,
    output logic       dir_up,
    output logic       fault
);

    localparam int unsigned DCW = (DISPATCH_TIMEOUT > 1) ? $clog2(DISPATCH_TIMEOUT) : 1;

    if (DWELL_CYCLES < 1 || DISPATCH_TIMEOUT < 1) begin : g_param_check
        $error("elevator_call_scheduler: DWELL_CYCLES and DISPATCH_TIMEOUT must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISPATCH,
        S_MOVING,
        S_ARRIVED,
        S_FAULT
    } state_t;

    state_t           state, next;
    logic [2:0]       btn_s1, btn_s2, btn_d;
    logic [1:0]       cur_floor, target;
    logic [DCW-1:0]   dcnt;
    logic             rst_hold;

    logic             f_multi, f_hit, arrive;
    logic [1:0]       f_num, up_sel, down_sel, sel_floor;
    logic             sel_dir;
    logic [2:0]       btn_rise, set_mask, clr_mask, pend_next;

    function automatic logic [2:0] floor_oh(input logic [1:0] fl);
        case (fl)
            2'd1:    return 3'b001;
            2'd2:    return 3'b010;
            2'd3:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    always_comb begin
        f_multi = (f[0] & f[1]) | (f[0] & f[2]) | (f[1] & f[2]);
        case (f)
            3'b001:  f_num = 2'd1;
            3'b010:  f_num = 2'd2;
            3'b100:  f_num = 2'd3;
            default: f_num = 2'd0;
        endcase
        f_hit = |(f & floor_oh(target));
    end

    // Later assignments win, so each search ends on the pending floor closest to cur_floor.
    always_comb begin
        up_sel   = '0;
        down_sel = '0;
        if (cur_floor < 2'd3 && pend[2]) up_sel = 2'd3;
        if (cur_floor < 2'd2 && pend[1]) up_sel = 2'd2;
        if (cur_floor > 2'd1 && pend[0]) down_sel = 2'd1;
        if (cur_floor > 2'd2 && pend[1]) down_sel = 2'd2;

        sel_floor = '0;
        sel_dir   = dir_up;
        if (|(pend & floor_oh(cur_floor))) begin
            sel_floor = cur_floor;
        end else if (dir_up) begin
            if (up_sel != 2'd0) begin
                sel_floor = up_sel;
            end else if (down_sel != 2'd0) begin
                sel_floor = down_sel;
                sel_dir   = 1'b0;
            end
        end else begin
            if (down_sel != 2'd0) begin
                sel_floor = down_sel;
            end else if (up_sel != 2'd0) begin
                sel_floor = up_sel;
                sel_dir   = 1'b1;
            end
        end
    end

`ifdef ELEVATOR_DOOR_DWELL_EN
    logic [15:0] wcnt;
    logic        dwell_done;

    assign dwell_done = (wcnt == 16'(DWELL_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            wcnt <= '0;
        end else if (state == S_ARRIVED && next == S_ARRIVED) begin
            wcnt <= wcnt + 16'd1;
        end else begin
            wcnt <= '0;
        end
    end
`else
    logic dwell_done;

    assign dwell_done = 1'b1;
`endif

    always_comb begin
        next   = state;
        arrive = 1'b0;
        case (state)
            S_IDLE: begin
                if (|pend && cur_floor != 2'd0) next = S_DISPATCH;
            end
            S_DISPATCH: begin
                if (f_hit) begin
                    next   = S_ARRIVED;
                    arrive = 1'b1;
                end else if (mup | mdw) begin
                    next = S_MOVING;
                end else if (dcnt == DCW'(DISPATCH_TIMEOUT - 1)) begin
                    next = S_IDLE;
                end
            end
            S_MOVING: begin
                if (f_hit && !mup && !mdw) begin
                    next   = S_ARRIVED;
                    arrive = 1'b1;
                end
            end
            S_ARRIVED: begin
                if (dwell_done) next = S_IDLE;
            end
            default: next = S_FAULT;
        endcase
        if (f_multi) begin
            next   = S_FAULT;
            arrive = 1'b0;
        end
    end

    // Clearing the target on arrival takes priority over a same-edge press of that floor.
    always_comb begin
        btn_rise = btn_s2 & ~btn_d;
        set_mask = btn_rise;
        if (state == S_IDLE || state == S_ARRIVED) set_mask = btn_rise & ~floor_oh(cur_floor);
        clr_mask = arrive ? floor_oh(target) : 3'b000;
        if (state == S_FAULT || f_multi) begin
            pend_next = pend;
        end else begin
            pend_next = (pend | set_mask) & ~clr_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            btn_s1    <= '0;
            btn_s2    <= '0;
            btn_d     <= '0;
            cur_floor <= '0;
            target    <= '0;
            dir_up    <= 1'b1;
            pend      <= '0;
            dcnt      <= '0;
            rst_hold  <= 1'b1;
        end else begin
            state    <= next;
            rst_hold <= 1'b0;
            btn_s1   <= btn;
            btn_s2   <= btn_s1;
            btn_d    <= btn_s2;
            pend     <= pend_next;
            if (f_num != 2'd0) cur_floor <= f_num;
            if (state == S_IDLE && next == S_DISPATCH) begin
                target <= sel_floor;
                dir_up <= sel_dir;
            end
            if (state == S_DISPATCH && next == S_DISPATCH) begin
                dcnt <= dcnt + DCW'(1);
            end else begin
                dcnt <= '0;
            end
        end
    end

    always_comb begin
        p         = (state == S_DISPATCH) ? floor_oh(target) : 3'b000;
        s         = rst_hold || state == S_ARRIVED || state == S_FAULT;
        door_open = (state == S_ARRIVED);
        fault     = (state == S_FAULT);
    end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Scenario bench for elevator_call_scheduler; expected dispatch targets flow through a scoreboard queue.
module tb_elevator_call_scheduler;

    localparam int DWELL   = 6;
    localparam int TIMEOUT = 15;
`ifdef ELEVATOR_DOOR_DWELL_EN
    localparam int DWELL_EXP = DWELL;
`else
    localparam int DWELL_EXP = 1;
`endif

    logic       clk;
    logic       reset;
    logic [2:0] btn, f;
    logic       mup, mdw;
    logic [2:0] p, pend;
    logic       s, door_open, dir_up, fault;

    logic [2:0] exp_q[$];
    int         errors = 0;
    int         checks = 0;

    elevator_call_scheduler #(
        .DWELL_CYCLES     (DWELL),
        .DISPATCH_TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn       (btn),
        .f         (f),
        .mup       (mup),
        .mdw       (mdw),
        .p         (p),
        .s         (s),
        .pend      (pend),
        .door_open (door_open),
        .dir_up    (dir_up),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [2:0] floor_bits);
        reset = 1'b0; f = floor_bits; btn = '0; mup = 1'b0; mdw = 1'b0;
        step(2);
        reset = 1'b1;
        exp_q.delete();
    endtask

    task automatic wait_p(input string tag);
        int i = 0;
        logic [2:0] e;
        while (p == 3'b000 && i < 40) begin step(1); i++; end
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL %s: p=%b with no request queued", tag, p);
        end else begin
            e = exp_q.pop_front();
            if (p !== e) begin errors++; $display("FAIL %s: p=%b expected %b", tag, p, e); end
        end
    endtask

    task automatic wait_door(input string tag);
        int i = 0;
        int n = 0;
        while (door_open !== 1'b1 && i < 40) begin step(1); i++; end
        while (door_open === 1'b1 && n < 3000) begin n++; step(1); end
        checks++;
        if (n != DWELL_EXP) begin errors++; $display("FAIL %s: door open %0d cycles expected %0d", tag, n, DWELL_EXP); end
    endtask

    task automatic test_reset;
        reset = 1'b0; f = 3'b001; btn = '0; mup = 1'b0; mdw = 1'b0;
        step(2);
        checks++; if (p !== 3'b000) begin errors++; $display("FAIL rst_p: got %b expected 000", p); end
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL rst_s: got %b expected 1", s); end
        checks++; if (pend !== 3'b000) begin errors++; $display("FAIL rst_pend: got %b expected 000", pend); end
        checks++; if (door_open !== 1'b0) begin errors++; $display("FAIL rst_door: got %b expected 0", door_open); end
        checks++; if (dir_up !== 1'b1) begin errors++; $display("FAIL rst_dir: got %b expected 1", dir_up); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b expected 0", fault); end
        reset = 1'b1;
        step(1);
        checks++; if (s !== 1'b0) begin errors++; $display("FAIL rst_s_release: got %b expected 0", s); end
    endtask

    task automatic test_basic;
        do_reset(3'b001);
        step(1);
        btn = 3'b100; exp_q.push_back(3'b100);
        step(1);
        btn = 3'b000;
        step(1);
        checks++; if (pend !== 3'b000) begin errors++; $display("FAIL basic_pend_early: got %b expected 000", pend); end
        step(1);
        checks++; if (pend !== 3'b100) begin errors++; $display("FAIL basic_pend: got %b expected 100", pend); end
        step(1);
        checks++; if (p !== 3'b100) begin errors++; $display("FAIL basic_p_latency: got %b expected 100", p); end
        wait_p("basic_target");
        mup = 1'b1;
        step(1);
        checks++; if (p !== 3'b000) begin errors++; $display("FAIL basic_p_drop: got %b expected 000", p); end
        checks++; if (s !== 1'b0) begin errors++; $display("FAIL basic_s_moving: got %b expected 0", s); end
        f = 3'b000;
        step(2);
        f = 3'b100; mup = 1'b0;
        step(1);
        checks++; if (pend !== 3'b000) begin errors++; $display("FAIL basic_pend_clear: got %b expected 000", pend); end
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL basic_s_arrived: got %b expected 1", s); end
        wait_door("basic_dwell");
    endtask

    task automatic test_sweep;
        do_reset(3'b010);
        step(1);
        btn = 3'b101; exp_q.push_back(3'b100); exp_q.push_back(3'b001);
        step(1);
        btn = 3'b000;
        step(2);
        checks++; if (pend !== 3'b101) begin errors++; $display("FAIL sweep_pend: got %b expected 101", pend); end
        wait_p("sweep_first");
        checks++; if (dir_up !== 1'b1) begin errors++; $display("FAIL sweep_dir_up: got %b expected 1", dir_up); end
        mup = 1'b1;
        step(1);
        f = 3'b000;
        step(1);
        f = 3'b100; mup = 1'b0;
        step(1);
        checks++; if (pend !== 3'b001) begin errors++; $display("FAIL sweep_pend_after3: got %b expected 001", pend); end
        wait_door("sweep_dwell3");
        wait_p("sweep_second");
        checks++; if (dir_up !== 1'b0) begin errors++; $display("FAIL sweep_dir_rev: got %b expected 0", dir_up); end
        mdw = 1'b1;
        step(1);
        f = 3'b000;
        step(1);
        f = 3'b001; mdw = 1'b0;
        step(1);
        checks++; if (pend !== 3'b000) begin errors++; $display("FAIL sweep_pend_after1: got %b expected 000", pend); end
        wait_door("sweep_dwell1");
    endtask

    task automatic test_timeout;
        int n = 0;
        btn = 3'b010; exp_q.push_back(3'b010);
        step(1);
        btn = 3'b000;
        step(2);
        checks++; if (pend !== 3'b010) begin errors++; $display("FAIL tmo_pend: got %b expected 010", pend); end
        wait_p("tmo_target");
        while (p === 3'b010 && n < 100) begin n++; step(1); end
        checks++; if (n != TIMEOUT) begin errors++; $display("FAIL tmo_len: p held %0d cycles expected %0d", n, TIMEOUT); end
        checks++; if (p !== 3'b000) begin errors++; $display("FAIL tmo_p_drop: got %b expected 000", p); end
        checks++; if (pend !== 3'b010) begin errors++; $display("FAIL tmo_pend_kept: got %b expected 010", pend); end
        step(1);
        checks++; if (p !== 3'b010) begin errors++; $display("FAIL tmo_redispatch: got %b expected 010", p); end
        f = 3'b010;
        step(1);
        checks++; if (door_open !== 1'b1) begin errors++; $display("FAIL at_floor_door: got %b expected 1", door_open); end
        checks++; if (pend !== 3'b000) begin errors++; $display("FAIL at_floor_pend: got %b expected 000", pend); end
        wait_door("at_floor_dwell");
    endtask

    task automatic test_fault;
        btn = 3'b001; exp_q.push_back(3'b001);
        step(1);
        btn = 3'b000;
        wait_p("fault_target");
        mdw = 1'b1;
        step(1);
        checks++; if (p !== 3'b000) begin errors++; $display("FAIL fault_moving_p: got %b expected 000", p); end
        f = 3'b011;
        step(1);
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_flag: got %b expected 1", fault); end
        checks++; if (p !== 3'b000) begin errors++; $display("FAIL fault_p: got %b expected 000", p); end
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL fault_s: got %b expected 1", s); end
        checks++; if (door_open !== 1'b0) begin errors++; $display("FAIL fault_door: got %b expected 0", door_open); end
        btn = 3'b100;
        step(1);
        btn = 3'b000;
        step(5);
        checks++; if (pend !== 3'b001) begin errors++; $display("FAIL fault_pend_frozen: got %b expected 001", pend); end
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_sticky: got %b expected 1", fault); end
        mdw = 1'b0;
    endtask

    task automatic test_reset_arrived;
        do_reset(3'b001);
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL ra_fault_clr: got %b expected 0", fault); end
        step(1);
        btn = 3'b010; exp_q.push_back(3'b010);
        step(1);
        btn = 3'b000;
        wait_p("ra_target");
        mup = 1'b1;
        step(1);
        btn = 3'b100;
        step(1);
        btn = 3'b000; f = 3'b000;
        step(3);
        checks++; if (pend !== 3'b110) begin errors++; $display("FAIL ra_pend_moving: got %b expected 110", pend); end
        f = 3'b010; mup = 1'b0;
        step(1);
        checks++; if (door_open !== 1'b1) begin errors++; $display("FAIL ra_door: got %b expected 1", door_open); end
        checks++; if (pend !== 3'b100) begin errors++; $display("FAIL ra_pend_arrive: got %b expected 100", pend); end
        reset = 1'b0;
        step(1);
        checks++; if (door_open !== 1'b0) begin errors++; $display("FAIL ra_door_rst: got %b expected 0", door_open); end
        checks++; if (pend !== 3'b000) begin errors++; $display("FAIL ra_pend_rst: got %b expected 000", pend); end
        checks++; if (dir_up !== 1'b1) begin errors++; $display("FAIL ra_dir_rst: got %b expected 1", dir_up); end
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL ra_s_rst: got %b expected 1", s); end
        reset = 1'b1; btn = 3'b010;
        step(1);
        btn = 3'b000;
        step(5);
        checks++; if (pend !== 3'b000) begin errors++; $display("FAIL ra_cur_ignored: got %b expected 000", pend); end
        checks++; if (s !== 1'b0) begin errors++; $display("FAIL ra_s_idle: got %b expected 0", s); end
        checks++; if (p !== 3'b000) begin errors++; $display("FAIL ra_p_idle: got %b expected 000", p); end
    endtask

    initial begin
        reset = 1'b0; btn = '0; f = 3'b001; mup = 1'b0; mdw = 1'b0;
        test_reset();
        test_basic();
        test_sweep();
        test_timeout();
        test_fault();
        test_reset_arrived();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
